// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time through a
// coin hopper handshake, greedy order quarter -> dime -> nickel, while
// tracking per-denomination inventory and reporting any unpaid residue.
// Optional feature: define CHANGE_DISPENSE_TIMEOUT_EN to abort a payout when
// the hopper fails to acknowledge a coin within TIMEOUT cycles.
module change_dispenser #(
  parameter int unsigned INV_Q   = 8,
  parameter int unsigned INV_D   = 8,
  parameter int unsigned INV_N   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [5:0] change,
  output logic       chg_ready,
  output logic [2:0] coin_out,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic [5:0] short_amt,
  output logic       fault,
  output logic [4:0] inv_q,
  output logic [4:0] inv_d,
  output logic [4:0] inv_n,
  input  logic       refill
);

  // Parameter sanity: inventories fit the 5-bit counters, timeout fits the
  // 6-bit cycle counter and is non-zero.
  if (INV_Q > 31 || INV_D > 31 || INV_N > 31) begin : gBadInventory
    $error("change_dispenser: INV_* must be in 0..31");
  end
  if (TIMEOUT < 1 || TIMEOUT > 63) begin : gBadTimeout
    $error("change_dispenser: TIMEOUT must be in 1..63");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DISPENSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [2:0] COIN_N = 3'b001;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_Q = 3'b100;

  localparam logic [4:0] FULL_Q = 5'(INV_Q);
  localparam logic [4:0] FULL_D = 5'(INV_D);
  localparam logic [4:0] FULL_N = 5'(INV_N);

  state_t     state_q, state_d;
  logic [5:0] remaining_q, remaining_d;
  logic [2:0] pick_q, pick_d;
  logic [4:0] qtyQ_q, qtyQ_d;
  logic [4:0] qtyD_q, qtyD_d;
  logic [4:0] qtyN_q, qtyN_d;
  logic [5:0] short_q, short_d;

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
  logic       fault_q, fault_d;
  logic [5:0] tmo_q, tmo_d;
`endif

  // Cents value of a one-hot coin code.
  function automatic logic [5:0] coinValue(input logic [2:0] coin);
    logic [5:0] value;
    value = 6'd0;
    case (coin)
      COIN_Q:  value = 6'd25;
      COIN_D:  value = 6'd10;
      COIN_N:  value = 6'd5;
      default: value = 6'd0;
    endcase
    return value;
  endfunction

  // State and datapath registers; reset reloads inventory and discards any
  // outstanding payout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 6'd0;
      pick_q      <= 3'b000;
      qtyQ_q      <= FULL_Q;
      qtyD_q      <= FULL_D;
      qtyN_q      <= FULL_N;
      short_q     <= 6'd0;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
      fault_q     <= 1'b0;
      tmo_q       <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pick_q      <= pick_d;
      qtyQ_q      <= qtyQ_d;
      qtyD_q      <= qtyD_d;
      qtyN_q      <= qtyN_d;
      short_q     <= short_d;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
      fault_q     <= fault_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state logic: accept, greedy coin selection, handshake, completion.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pick_d      = pick_q;
    qtyQ_d      = qtyQ_q;
    qtyD_d      = qtyD_q;
    qtyN_d      = qtyN_q;
    short_d     = short_q;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
    fault_d     = fault_q;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (refill) begin
          qtyQ_d = FULL_Q;
          qtyD_d = FULL_D;
          qtyN_d = FULL_N;
        end
        if (chg_valid) begin
          remaining_d = change;
          short_d     = 6'd0;
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
          fault_d     = 1'b0;
`endif
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining_q >= 6'd25 && qtyQ_q != 5'd0) begin
          pick_d  = COIN_Q;
          state_d = S_DISPENSE;
        end else if (remaining_q >= 6'd10 && qtyD_q != 5'd0) begin
          pick_d  = COIN_D;
          state_d = S_DISPENSE;
        end else if (remaining_q >= 6'd5 && qtyN_q != 5'd0) begin
          pick_d  = COIN_N;
          state_d = S_DISPENSE;
        end else begin
          short_d = remaining_q;
          state_d = S_DONE;
        end
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
        tmo_d = 6'd0;
`endif
      end

      S_DISPENSE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coinValue(pick_q);
          if (pick_q == COIN_Q && qtyQ_q != 5'd0) qtyQ_d = qtyQ_q - 5'd1;
          if (pick_q == COIN_D && qtyD_q != 5'd0) qtyD_d = qtyD_q - 5'd1;
          if (pick_q == COIN_N && qtyN_q != 5'd0) qtyN_d = qtyN_q - 5'd1;
          state_d = S_GAP;
        end
`ifdef CHANGE_DISPENSE_TIMEOUT_EN
        else if (tmo_q == 6'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          short_d = remaining_q;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
`endif
      end

      S_GAP: begin
        state_d = S_SELECT;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from state and registered values only.
  assign chg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign coin_out  = (state_q == S_DISPENSE) ? pick_q : 3'b000;
  assign short_amt = short_q;
  assign inv_q     = qtyQ_q;
  assign inv_d     = qtyD_q;
  assign inv_n     = qtyN_q;

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized payouts of change_dispenser
// against a transaction-level greedy payout model with inventory tracking.
module tb_change_dispenser;

  localparam int INV_Q = 8;
  localparam int INV_D = 8;
  localparam int INV_N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       chg_valid;
  logic [5:0] change;
  logic       chg_ready;
  logic [2:0] coin_out;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic [5:0] short_amt;
  logic       fault;
  logic [4:0] inv_q;
  logic [4:0] inv_d;
  logic [4:0] inv_n;
  logic       refill;

  int checks   = 0;
  int failures = 0;
  int modelQ;
  int modelD;
  int modelN;

  change_dispenser #(
    .INV_Q(INV_Q),
    .INV_D(INV_D),
    .INV_N(INV_N),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chg_valid(chg_valid),
    .change(change),
    .chg_ready(chg_ready),
    .coin_out(coin_out),
    .coin_ack(coin_ack),
    .busy(busy),
    .done(done),
    .short_amt(short_amt),
    .fault(fault),
    .inv_q(inv_q),
    .inv_d(inv_d),
    .inv_n(inv_n),
    .refill(refill)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkInventory(input string tag);
    checkOutput({tag, "_invQ"}, 32'(inv_q), modelQ);
    checkOutput({tag, "_invD"}, 32'(inv_d), modelD);
    checkOutput({tag, "_invN"}, 32'(inv_n), modelN);
  endtask

  task automatic reloadModel();
    modelQ = INV_Q;
    modelD = INV_D;
    modelN = INV_N;
  endtask

  // One complete payout: accept, follow every coin with a random ack delay
  // (0..maxDelay extra cycles), and check coins, residue, inventory, timing.
  task automatic applyStimulus(input int amount, input int maxDelay,
                               input bit doRefill, input bit noise);
    int  expCoins[$];
    int  rem;
    int  expShort;
    int  expCycles;
    int  busyCycles;
    int  waitCnt;
    int  target;
    int  expCoin;
    bit  prevCoin;
    bit  seenDone;

    checkOutput("readyBeforeAccept", 32'(chg_ready), 1);
    if (doRefill) reloadModel();

    rem = amount;
    while (1) begin
      if (rem >= 25 && modelQ > 0) begin
        expCoins.push_back(4); rem -= 25; modelQ--;
      end else if (rem >= 10 && modelD > 0) begin
        expCoins.push_back(2); rem -= 10; modelD--;
      end else if (rem >= 5 && modelN > 0) begin
        expCoins.push_back(1); rem -= 5; modelN--;
      end else begin
        break;
      end
    end
    expShort = rem;

    chg_valid = 1'b1;
    change    = 6'(amount);
    refill    = doRefill;
    coin_ack  = noise ? 1'($urandom) : 1'b0;
    tick();
    chg_valid = 1'b0;
    refill    = 1'b0;
    change    = 6'($urandom);

    checkOutput("busyAfterAccept", 32'(busy), 1);
    checkOutput("readyAfterAccept", 32'(chg_ready), 0);
    checkOutput("shortCleared", 32'(short_amt), 0);

    expCycles  = 2;
    busyCycles = 0;
    seenDone   = 1'b0;
    prevCoin   = 1'b0;
    waitCnt    = 0;
    target     = 0;
    for (int cyc = 0; cyc < 600 && !seenDone; cyc++) begin
      if (busy) busyCycles++;
      if (done) begin
        seenDone = 1'b1;
        coin_ack = 1'b0;
        refill   = 1'b0;
        checkOutput("doneShort", 32'(short_amt), expShort);
        checkOutput("doneFault", 32'(fault), 0);
        checkOutput("coinsLeftOver", expCoins.size(), 0);
        checkInventory("done");
      end else begin
        if (coin_out != 3'b000) begin
          if (!prevCoin) begin
            expCoin = (expCoins.size() > 0) ? expCoins.pop_front() : 0;
            checkOutput("coinValue", 32'(coin_out), expCoin);
            target = $urandom_range(0, maxDelay);
            expCycles += 3 + target;
            waitCnt = 0;
          end
          coin_ack = (waitCnt == target);
          waitCnt++;
          prevCoin = 1'b1;
        end else begin
          prevCoin = 1'b0;
          coin_ack = noise ? 1'($urandom) : 1'b0;
        end
        refill = noise ? 1'($urandom) : 1'b0;
        tick();
      end
    end

    if (!seenDone) begin
      checkOutput("doneTimeout", 0, 1);
      coin_ack = 1'b0;
      refill   = 1'b0;
    end else begin
      checkOutput("payoutCycles", busyCycles, expCycles);
      tick();
      checkOutput("readyAfterDone", 32'(chg_ready), 1);
      checkOutput("idleNotBusy", 32'(busy), 0);
      checkOutput("doneOnePulse", 32'(done), 0);
      checkOutput("shortHeld", 32'(short_amt), expShort);
    end
  endtask

  initial begin
    reset     = 1'b1;
    chg_valid = 1'b0;
    change    = 6'd0;
    coin_ack  = 1'b0;
    refill    = 1'b0;
    reloadModel();
    tick();
    tick();
    reset = 1'b0;

    // Reset values.
    checkOutput("rstReady", 32'(chg_ready), 1);
    checkOutput("rstCoin", 32'(coin_out), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstShort", 32'(short_amt), 0);
    checkOutput("rstFault", 32'(fault), 0);
    checkInventory("rst");

    // Ack while idle must be ignored.
    coin_ack = 1'b1;
    tick();
    tick();
    coin_ack = 1'b0;
    checkOutput("idleAckReady", 32'(chg_ready), 1);
    checkOutput("idleAckCoin", 32'(coin_out), 0);
    checkInventory("idleAck");

    // Directed payouts: 40 with immediate ack, 37 with residue, zero.
    applyStimulus(40, 0, 1'b0, 1'b0);
    applyStimulus(37, 2, 1'b0, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // Reset in the middle of the second coin of a 35-cent payout.
    chg_valid = 1'b1;
    change    = 6'd35;
    tick();
    chg_valid = 1'b0;
    tick();
    checkOutput("midFirstCoin", 32'(coin_out), 4);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    tick();
    checkOutput("midSecondCoin", 32'(coin_out), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reloadModel();
    checkOutput("midRstReady", 32'(chg_ready), 1);
    checkOutput("midRstCoin", 32'(coin_out), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    checkInventory("midRst");
    applyStimulus(35, 1, 1'b0, 1'b0);

    // Randomized payouts with ack delays and idle-ack/refill noise; the
    // inventory drains so quarter and dime fallbacks get exercised.
    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom_range(0, 63), 3, 1'b0, 1'b1);
    end

    // Refill together with an accept: refill applies first, accept taken.
    applyStimulus(40, 1, 1'b1, 1'b0);

    // Hopper never acks: dispenser waits on the dime indefinitely.
    chg_valid = 1'b1;
    change    = 6'd10;
    tick();
    chg_valid = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) tick();
    checkOutput("hangBusy", 32'(busy), 1);
    checkOutput("hangCoin", 32'(coin_out), 2);
    checkOutput("hangFault", 32'(fault), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reloadModel();
    checkOutput("hangRstReady", 32'(chg_ready), 1);
    checkInventory("hangRst");

    $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
